// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns a debounced button level into gesture events: press, release, single
// click, double click and long press, plus a `held` level. Every gesture
// window is measured in `tick` periods, so the timing follows the system
// timebase rather than the raw clock.
//
// Build option:
//   BUTTON_EVENT_DOUBLE_CLICK_EN  defined   -> full double-click FSM. A click
//                                              is reported only after the
//                                              double-click window expires.
//                                 undefined -> no double-click states. A click
//                                              is reported together with the
//                                              release, and ev_double is
//                                              tied to 0.
//
// Ports:
//   aclk            in  clock, rising edge
//   reset           in  synchronous reset, active-high
//   en              in  enable, asynchronous; goes through a 2-FF synchroniser
//   tick            in  one-cycle timebase strobe
//   button_filtered in  debounced button level, 1 = pressed
//   ev_press        out one-cycle pulse on each press
//   ev_release      out one-cycle pulse on each release
//   ev_click        out one-cycle pulse for a completed single click
//   ev_double       out one-cycle pulse for a completed double click
//   ev_long         out one-cycle pulse when a press reaches P_LONG_TICKS
//   held            out level, 1 while the button is held as part of a gesture
//
// All outputs are registered. The event pulses follow the input edge, or the
// qualifying tick, by one aclk.
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int unsigned P_LONG_TICKS   = 100,  // >= 2
  parameter int unsigned P_DCLICK_TICKS = 30    // >= 2
) (
  input  logic aclk,
  input  logic reset,
  input  logic en,
  input  logic tick,
  input  logic button_filtered,
  output logic ev_press,
  output logic ev_release,
  output logic ev_click,
  output logic ev_double,
  output logic ev_long,
  output logic held
);

  localparam int unsigned MAX_TICKS =
    (P_LONG_TICKS > P_DCLICK_TICKS) ? P_LONG_TICKS : P_DCLICK_TICKS;
  localparam int CNT_W = $clog2(MAX_TICKS);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(P_LONG_TICKS - 1);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(P_DCLICK_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    ,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
`endif
  } state_t;

  // Enable synchroniser
  logic en_meta;
  logic en_s;

  // Edge detection
  logic btn_q;
  logic rise;
  logic fall;

  // After a reset, btn_q is held at 0 until the block is first enabled.
  // That way a button still held through the reset is reported as a new
  // press once the block is enabled again.
  logic rst_pend;

  // FSM and tick counter
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next values of the registered outputs
  logic press_nxt;
  logic release_nxt;
  logic click_nxt;
  logic double_nxt;
  logic long_nxt;
  logic held_nxt;

  assign rise = button_filtered & ~btn_q;
  assign fall = ~button_filtered & btn_q;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    double_nxt  = 1'b0;
    long_nxt    = 1'b0;

    if (!en_s) begin
      // Disabling the block abandons any gesture in progress. No event is
      // reported for it.
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            press_nxt = 1'b1;
            state_nxt = ST_PRESSED;
          end
        end

        ST_PRESSED: begin
          // A release wins over a long-press tick that lands in the same cycle.
          if (fall) begin
            release_nxt = 1'b1;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
            state_nxt   = ST_WAIT_SECOND;
`else
            click_nxt   = 1'b1;
            state_nxt   = ST_IDLE;
`endif
          end else if (tick && cnt == LONG_LAST) begin
            long_nxt  = 1'b1;
            state_nxt = ST_LONG_HELD;
          end
        end

        ST_LONG_HELD: begin
          if (fall) begin
            release_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end
        end

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
        ST_WAIT_SECOND: begin
          // A second press wins over a timeout tick that lands in the same
          // cycle.
          if (rise) begin
            press_nxt = 1'b1;
            state_nxt = ST_SECOND_PRESSED;
          end else if (tick && cnt == DCLICK_LAST) begin
            click_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end
        end

        ST_SECOND_PRESSED: begin
          if (fall) begin
            release_nxt = 1'b1;
            double_nxt  = 1'b1;
            state_nxt   = ST_IDLE;
          end else if (tick && cnt == LONG_LAST) begin
            // The first click is dropped. Holding the button this long
            // makes the gesture a long press.
            long_nxt  = 1'b1;
            state_nxt = ST_LONG_HELD;
          end
        end
`endif

        default: state_nxt = ST_IDLE;
      endcase
    end

    held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG_HELD)
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
               || (state_nxt == ST_SECOND_PRESSED)
`endif
               ;

    // The counter restarts on every state change and saturates at all-ones,
    // so a long stay in one state cannot wrap it back to a threshold.
    cnt_nxt = cnt;
    if (!en_s || state_nxt != state) begin
      cnt_nxt = '0;
    end else if (tick && cnt != {CNT_W{1'b1}}) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (reset) begin
      en_meta    <= 1'b0;
      en_s       <= 1'b0;
      btn_q      <= 1'b0;
      rst_pend   <= 1'b1;
      state      <= ST_IDLE;
      cnt        <= '0;
      ev_press   <= 1'b0;
      ev_release <= 1'b0;
      ev_click   <= 1'b0;
      ev_long    <= 1'b0;
      held       <= 1'b0;
    end else begin
      en_meta <= en;
      en_s    <= en_meta;
      // When disabled, btn_q still follows the button, so enabling with the
      // button already down does not look like a press. The exception is the
      // period between reset and the first enable.
      if (en_s || !rst_pend) begin
        btn_q <= button_filtered;
      end
      if (en_s) begin
        rst_pend <= 1'b0;
      end
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ev_press   <= press_nxt;
      ev_release <= release_nxt;
      ev_click   <= click_nxt;
      ev_long    <= long_nxt;
      held       <= held_nxt;
    end
  end

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  always_ff @(posedge aclk) begin
    if (reset) begin
      ev_double <= 1'b0;
    end else begin
      ev_double <= double_nxt;
    end
  end
`else
  assign ev_double = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Directed bench for button_event_decoder with P_LONG_TICKS=4 and
// P_DCLICK_TICKS=3. The bench drives tick once every 10 clocks. Inputs change
// 1 ns after each rising edge, and outputs are sampled at the same point.
// Expected behaviour follows the BUTTON_EVENT_DOUBLE_CLICK_EN setting of the
// build.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  logic aclk;
  logic reset;
  logic en;
  logic tick;
  logic button_filtered;
  logic ev_press;
  logic ev_release;
  logic ev_click;
  logic ev_double;
  logic ev_long;
  logic held;

  int vectors;
  int miscompares;
  int cyc_no;
  int tick_div;
  int ticks;
  int n_press, n_release, n_click, n_double, n_long;
  int release_cyc, double_cyc;
  int held_low;
  int mutex_viol;

  button_event_decoder #(
    .P_LONG_TICKS  (4),
    .P_DCLICK_TICKS(3)
  ) dut (
    .aclk           (aclk),
    .reset          (reset),
    .en             (en),
    .tick           (tick),
    .button_filtered(button_filtered),
    .ev_press       (ev_press),
    .ev_release     (ev_release),
    .ev_click       (ev_click),
    .ev_double      (ev_double),
    .ev_long        (ev_long),
    .held           (held)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one clock. Then record the outputs and set up tick for the next
  // edge.
  task automatic cyc();
    logic t;
    t = tick;
    @(posedge aclk);
    #1;
    cyc_no++;
    if (t) ticks++;
    if (ev_press === 1'b1) n_press++;
    if (ev_release === 1'b1) begin n_release++; release_cyc = cyc_no; end
    if (ev_click === 1'b1) n_click++;
    if (ev_double === 1'b1) begin n_double++; double_cyc = cyc_no; end
    if (ev_long === 1'b1) n_long++;
    if (held !== 1'b1) held_low++;
    if ((int'(ev_click === 1'b1) + int'(ev_double === 1'b1) + int'(ev_long === 1'b1)) > 1)
      mutex_viol++;
    tick_div = (tick_div == 9) ? 0 : tick_div + 1;
    tick = (tick_div == 9);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Run until n more ticks have been sampled. Returns just after the edge
  // that took the last of them.
  task automatic run_ticks(input int n);
    int target;
    target = ticks + n;
    for (int i = 0; i < n * 10 + 20 && ticks < target; i++) cyc();
    if (ticks < target) begin
      vectors++; miscompares++;
      $display("FAIL run_ticks_timeout: got %0d ticks want %0d", ticks, target);
    end
  endtask

  // Step until the next edge will sample tick=1.
  task automatic to_tick_edge();
    for (int i = 0; i < 20 && tick !== 1'b1; i++) cyc();
    if (tick !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL to_tick_timeout: got tick %b want 1", tick);
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_click = 0; n_double = 0; n_long = 0;
    release_cyc = -1; double_cyc = -2; held_low = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; en = 1'b1; button_filtered = 1'b0;
    run(4);
    vectors++; if (ev_press !== 1'b0) begin miscompares++; $display("FAIL reset_press: got %b want 0", ev_press); end
    vectors++; if (ev_release !== 1'b0) begin miscompares++; $display("FAIL reset_release: got %b want 0", ev_release); end
    vectors++; if (ev_click !== 1'b0) begin miscompares++; $display("FAIL reset_click: got %b want 0", ev_click); end
    vectors++; if (ev_double !== 1'b0) begin miscompares++; $display("FAIL reset_double: got %b want 0", ev_double); end
    vectors++; if (ev_long !== 1'b0) begin miscompares++; $display("FAIL reset_long: got %b want 0", ev_long); end
    vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", held); end
    reset = 1'b0;
    run(5);
  endtask

  task automatic test_single_click();
    clear_counts();
    button_filtered = 1'b1; cyc();
    vectors++; if (ev_press !== 1'b1) begin miscompares++; $display("FAIL click_press: got %b want 1", ev_press); end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL click_held: got %b want 1", held); end
    run_ticks(2);
    button_filtered = 1'b0; cyc();
    vectors++; if (ev_release !== 1'b1) begin miscompares++; $display("FAIL click_release: got %b want 1", ev_release); end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    vectors++; if (ev_click !== 1'b0) begin miscompares++; $display("FAIL click_early: got %b want 0", ev_click); end
    run_ticks(2);
    vectors++; if (n_click != 0) begin miscompares++; $display("FAIL click_before_third_tick: got %0d want 0", n_click); end
    run_ticks(1);
    vectors++; if (ev_click !== 1'b1) begin miscompares++; $display("FAIL click_third_tick: got %b want 1", ev_click); end
`else
    vectors++; if (ev_click !== 1'b1) begin miscompares++; $display("FAIL click_with_release: got %b want 1", ev_click); end
`endif
    run_ticks(4);
    vectors++; if (n_click != 1) begin miscompares++; $display("FAIL click_count: got %0d want 1", n_click); end
    vectors++; if (n_double != 0 || n_long != 0) begin miscompares++; $display("FAIL click_no_double_long: got %0d/%0d want 0/0", n_double, n_long); end
    vectors++; if (n_press != 1 || n_release != 1) begin miscompares++; $display("FAIL click_edges: got %0d/%0d want 1/1", n_press, n_release); end
  endtask

  task automatic test_double_click();
    clear_counts();
    button_filtered = 1'b1; cyc();
    run(3);
    button_filtered = 1'b0; cyc();
    run(5);
    button_filtered = 1'b1; cyc();
    vectors++; if (ev_press !== 1'b1) begin miscompares++; $display("FAIL dbl_second_press: got %b want 1", ev_press); end
    run(3);
    button_filtered = 1'b0; cyc();
    vectors++; if (ev_release !== 1'b1) begin miscompares++; $display("FAIL dbl_second_release: got %b want 1", ev_release); end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    vectors++; if (ev_double !== 1'b1) begin miscompares++; $display("FAIL dbl_pulse: got %b want 1", ev_double); end
    run_ticks(4);
    vectors++; if (n_double != 1 || n_click != 0) begin miscompares++; $display("FAIL dbl_counts: got %0d/%0d want 1/0", n_double, n_click); end
    vectors++; if (double_cyc != release_cyc) begin miscompares++; $display("FAIL dbl_align: got %0d want %0d", double_cyc, release_cyc); end
`else
    vectors++; if (ev_click !== 1'b1) begin miscompares++; $display("FAIL dbl_off_click: got %b want 1", ev_click); end
    run_ticks(4);
    vectors++; if (n_double != 0 || n_click != 2) begin miscompares++; $display("FAIL dbl_off_counts: got %0d/%0d want 0/2", n_double, n_click); end
`endif
    vectors++; if (n_press != 2 || n_release != 2) begin miscompares++; $display("FAIL dbl_edges: got %0d/%0d want 2/2", n_press, n_release); end
  endtask

  task automatic test_long_press();
    clear_counts();
    button_filtered = 1'b1; cyc();
    held_low = 0;
    run_ticks(3);
    vectors++; if (n_long != 0) begin miscompares++; $display("FAIL long_early: got %0d want 0", n_long); end
    run_ticks(1);
    vectors++; if (ev_long !== 1'b1) begin miscompares++; $display("FAIL long_fourth_tick: got %b want 1", ev_long); end
    run_ticks(2);
    vectors++; if (n_long != 1) begin miscompares++; $display("FAIL long_once: got %0d want 1", n_long); end
    vectors++; if (held_low != 0) begin miscompares++; $display("FAIL long_held_level: got %0d low cycles want 0", held_low); end
    button_filtered = 1'b0; cyc();
    vectors++; if (ev_release !== 1'b1 || ev_click !== 1'b0) begin miscompares++; $display("FAIL long_release: got rel=%b clk=%b want 1/0", ev_release, ev_click); end
    run_ticks(4);
    vectors++; if (n_click != 0 || n_double != 0 || held !== 1'b0) begin miscompares++; $display("FAIL long_after: got clk=%0d dbl=%0d held=%b want 0/0/0", n_click, n_double, held); end
  endtask

  task automatic test_race_long();
    clear_counts();
    button_filtered = 1'b1; cyc();
    run_ticks(3);
    to_tick_edge();
    button_filtered = 1'b0; cyc();
    vectors++; if (ev_release !== 1'b1 || ev_long !== 1'b0) begin miscompares++; $display("FAIL race_long_edge: got rel=%b long=%b want 1/0", ev_release, ev_long); end
`ifndef BUTTON_EVENT_DOUBLE_CLICK_EN
    vectors++; if (ev_click !== 1'b1) begin miscompares++; $display("FAIL race_long_click: got %b want 1", ev_click); end
`endif
    run_ticks(4);
    vectors++; if (n_long != 0 || n_click != 1) begin miscompares++; $display("FAIL race_long_counts: got long=%0d clk=%0d want 0/1", n_long, n_click); end
  endtask

  task automatic test_race_second();
    clear_counts();
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    button_filtered = 1'b1; cyc();
    run(3);
    button_filtered = 1'b0; cyc();
    run_ticks(2);
    to_tick_edge();
    button_filtered = 1'b1; cyc();
    vectors++; if (ev_press !== 1'b1 || ev_click !== 1'b0 || held !== 1'b1) begin miscompares++; $display("FAIL race_second_edge: got p=%b c=%b h=%b want 1/0/1", ev_press, ev_click, held); end
    run(3);
    button_filtered = 1'b0; cyc();
    vectors++; if (ev_double !== 1'b1) begin miscompares++; $display("FAIL race_second_double: got %b want 1", ev_double); end
    run_ticks(4);
    vectors++; if (n_click != 0) begin miscompares++; $display("FAIL race_second_noclick: got %0d want 0", n_click); end
`else
    to_tick_edge();
    button_filtered = 1'b1; cyc();
    vectors++; if (ev_press !== 1'b1 || held !== 1'b1) begin miscompares++; $display("FAIL press_on_tick: got p=%b h=%b want 1/1", ev_press, held); end
    run(3);
    button_filtered = 1'b0; cyc();
    vectors++; if (ev_click !== 1'b1 || ev_double !== 1'b0) begin miscompares++; $display("FAIL press_on_tick_click: got c=%b d=%b want 1/0", ev_click, ev_double); end
    run_ticks(4);
`endif
  endtask

  task automatic test_enable();
    clear_counts();
    button_filtered = 1'b1; cyc();
    run(3);
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL en_held_before: got %b want 1", held); end
    en = 1'b0;
    run(3);
    vectors++; if (held !== 1'b0 || ev_long !== 1'b0) begin miscompares++; $display("FAIL en_drop: got h=%b l=%b want 0/0", held, ev_long); end
    clear_counts();
    run(5);
    en = 1'b1;
    run(6);
    vectors++; if (n_press != 0 || held !== 1'b0) begin miscompares++; $display("FAIL en_reenable_held: got press=%0d held=%b want 0/0", n_press, held); end
    button_filtered = 1'b0; cyc();
    run_ticks(4);
    vectors++; if (n_release != 0 || n_click != 0 || n_long != 0) begin miscompares++; $display("FAIL en_abandon: got rel=%0d clk=%0d long=%0d want 0/0/0", n_release, n_click, n_long); end
  endtask

  task automatic test_reset_held();
    clear_counts();
    button_filtered = 1'b1; cyc();
    run(2);
    reset = 1'b1;
    run(2);
    vectors++; if (held !== 1'b0 || ev_press !== 1'b0 || ev_release !== 1'b0) begin miscompares++; $display("FAIL rst_held_outputs: got h=%b p=%b r=%b want 0/0/0", held, ev_press, ev_release); end
    reset = 1'b0;
    clear_counts();
    run(6);
    vectors++; if (n_press != 1 || held !== 1'b1) begin miscompares++; $display("FAIL rst_held_repress: got press=%0d held=%b want 1/1", n_press, held); end
    button_filtered = 1'b0; cyc();
    run_ticks(4);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vectors = 0; miscompares = 0; cyc_no = 0;
    tick_div = 0; tick = 1'b0; ticks = 0; mutex_viol = 0;
    reset = 1'b1; en = 1'b1; button_filtered = 1'b0;
    clear_counts();

    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_race_long();
    test_race_second();
    test_enable();
    test_reset_held();

    vectors++;
    if (mutex_viol != 0) begin
      miscompares++;
      $display("FAIL event_mutex: got %0d overlapping cycles want 0", mutex_viol);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
